// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI/local register arbiter.
package spi_reg_pkg;

    localparam int DATA_W      = 32;
    localparam int IDX_W       = 7;
    localparam int WR_FLAG_BIT = 7;
    localparam int ID_W        = 3;

    typedef enum logic {
        ARB    = 1'b0,
        ACCESS = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic              write;
        logic [DATA_W-1:0] wdata;
        logic [ID_W-1:0]   id;
    } req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after ptr_i, wrapping.
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [PTR_W-1:0] id_o
);

    always_comb begin : pick
        logic             found;
        logic [PTR_W-1:0] cand;
        // NOTE: every comb output gets a default first so no path can infer a latch.
        grant_o = '0;
        id_o    = '0;
        found   = 1'b0;
        cand    = '0;
        for (int off = 0; off < N_REQ; off++) begin
            cand = PTR_W'((int'(ptr_i) + off) % N_REQ);
            if (!found && valid_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                id_o          = cand;
            end
        end
    end

endmodule

// File: rtl/spi_reg_arbiter.sv
// Shared register file: 1-cycle SPI reads, change-detected SPI writes, round-robin local access.
// Build option SPI_WRITE_PROTECT_EN makes the upper half SPI read-only and enables sticky Spi_Err.
module spi_reg_arbiter
    import spi_reg_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int N_REGS = 32
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic [7:0]              Spi_Addr,
    input  logic [DATA_W-1:0]       Spi_Wr_Data,
    output logic [DATA_W-1:0]       Spi_Rd_Data,
    input  logic [N_REQ-1:0]        Req_Valid,
    input  logic [N_REQ-1:0]        Req_Write,
    input  logic [N_REQ*IDX_W-1:0]  Req_Addr,
    input  logic [N_REQ*DATA_W-1:0] Req_Wdata,
    output logic [N_REQ-1:0]        Req_Ready,
    output logic [DATA_W-1:0]       Req_Rdata,
    output logic                    Spi_Err
);

    localparam int PTR_W  = $clog2(N_REQ);
    localparam int REG_AW = $clog2(N_REGS);

    logic [DATA_W-1:0] regs_q [N_REGS];
    logic [DATA_W-1:0] shadow_q, spi_rd_q, spi_rd_d, rdata_q, loc_rd_data;
    logic [N_REQ-1:0]  ready_q, ready_d, grant;
    logic [PTR_W-1:0]  ptr_q, grant_id;
    arb_state_t        state_q, state_d;
    req_t              req_q;

    logic [IDX_W-1:0] spi_idx;
    logic spi_commit, spi_in_range, spi_prot, spi_wr_en;
    logic do_access, loc_in_range, loc_wr_en;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .valid_i (Req_Valid),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .id_o    (grant_id)
    );

    // A write commits only when the data word changes under a write-flagged address.
    assign spi_idx      = Spi_Addr[IDX_W-1:0];
    assign spi_commit   = Spi_Addr[WR_FLAG_BIT] && (Spi_Wr_Data != shadow_q);
    assign spi_in_range = int'(spi_idx) < N_REGS;
`ifdef SPI_WRITE_PROTECT_EN
    assign spi_prot     = int'(spi_idx) >= N_REGS / 2;
`else
    assign spi_prot     = 1'b0;
`endif
    assign spi_wr_en    = spi_commit && spi_in_range && !spi_prot;
    assign spi_rd_d     = spi_in_range ? regs_q[spi_idx[REG_AW-1:0]] : '0;

    assign loc_in_range = int'(req_q.idx) < N_REGS;
    assign loc_rd_data  = loc_in_range ? regs_q[req_q.idx[REG_AW-1:0]] : '0;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state_q <= ARB;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB:    if (|grant)      state_d = ACCESS;
            ACCESS: if (!spi_commit) state_d = ARB;
            default:                 state_d = ARB;
        endcase
    end

    always_comb begin
        do_access = (state_q == ACCESS) && !spi_commit;
        loc_wr_en = do_access && req_q.write && loc_in_range;
        ready_d   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            ready_d[i] = do_access && (int'(req_q.id) == i);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ptr_q <= '0;
            req_q <= '0;
        end else begin
            if (state_q == ARB && |grant) begin
                req_q.idx   <= Req_Addr[grant_id*IDX_W +: IDX_W];
                req_q.write <= Req_Write[grant_id];
                req_q.wdata <= Req_Wdata[grant_id*DATA_W +: DATA_W];
                req_q.id    <= ID_W'(grant_id);
            end
            if (do_access) ptr_q <= PTR_W'((int'(req_q.id) + 1) % N_REQ);
        end
    end

    // NOTE: the register array is reset because software expects all registers to read 0 after reset.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < N_REGS; i++) regs_q[i] <= '0;
        end else if (spi_wr_en) begin
            regs_q[spi_idx[REG_AW-1:0]] <= Spi_Wr_Data;
        end else if (loc_wr_en) begin
            regs_q[req_q.idx[REG_AW-1:0]] <= req_q.wdata;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            shadow_q <= '0;
            spi_rd_q <= '0;
            ready_q  <= '0;
            rdata_q  <= '0;
        end else begin
            shadow_q <= Spi_Wr_Data;
            spi_rd_q <= spi_rd_d;
            ready_q  <= ready_d;
            if (do_access && !req_q.write) rdata_q <= loc_rd_data;
        end
    end

`ifdef SPI_WRITE_PROTECT_EN
    logic err_q;
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)                                  err_q <= 1'b0;
        else if (spi_commit && spi_in_range && spi_prot) err_q <= 1'b1;
    end
    assign Spi_Err = err_q;
`else
    assign Spi_Err = 1'b0;
`endif

    assign Spi_Rd_Data = spi_rd_q;
    assign Req_Ready   = ready_q;
    assign Req_Rdata   = rdata_q;

endmodule

// File: tb/tb_spi_reg_arbiter.sv
// Scoreboard bench for spi_reg_arbiter: directed cases plus randomized traffic against a register-array model.
module tb_spi_reg_arbiter;

    localparam int N_REQ  = 4;
    localparam int N_REGS = 32;

    logic                Clk;
    logic                Reset_n;
    logic [7:0]          Spi_Addr;
    logic [31:0]         Spi_Wr_Data;
    logic [31:0]         Spi_Rd_Data;
    logic [N_REQ-1:0]    Req_Valid;
    logic [N_REQ-1:0]    Req_Write;
    logic [N_REQ*7-1:0]  Req_Addr;
    logic [N_REQ*32-1:0] Req_Wdata;
    logic [N_REQ-1:0]    Req_Ready;
    logic [31:0]         Req_Rdata;
    logic                Spi_Err;

    spi_reg_arbiter #(.N_REQ(N_REQ), .N_REGS(N_REGS)) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .Spi_Addr    (Spi_Addr),
        .Spi_Wr_Data (Spi_Wr_Data),
        .Spi_Rd_Data (Spi_Rd_Data),
        .Req_Valid   (Req_Valid),
        .Req_Write   (Req_Write),
        .Req_Addr    (Req_Addr),
        .Req_Wdata   (Req_Wdata),
        .Req_Ready   (Req_Ready),
        .Req_Rdata   (Req_Rdata),
        .Spi_Err     (Spi_Err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        int          id;
        bit          rd;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          ready_cyc[$];
    logic [31:0] model [128];
    logic [31:0] shadow_m;
    logic [31:0] last_rdata_m;
    int          n_total = 0;
    int          n_pass  = 0;
    int          cyc     = 0;
    exp_t        mon_e;

    always @(posedge Clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: pops one expectation per Req_Ready pulse.
    always @(negedge Clk) begin
        if (Reset_n && Req_Ready != '0) begin
            if (sb.size() == 0) begin
                check("unexpected_ready", 32'(Req_Ready), 32'h0);
            end else begin
                mon_e = sb.pop_front();
                check("ready_onehot", 32'(Req_Ready), 32'(1) << mon_e.id);
                check(mon_e.rd ? "req_rdata" : "req_rdata_hold", Req_Rdata, mon_e.data);
                ready_cyc.push_back(cyc);
            end
        end
    end

    task automatic clear_model();
        for (int i = 0; i < 128; i++) model[i] = '0;
        shadow_m     = '0;
        last_rdata_m = '0;
    endtask

    task automatic do_reset();
        Reset_n     = 1'b0;
        Req_Valid   = '0;
        Req_Write   = '0;
        Spi_Addr    = '0;
        Spi_Wr_Data = '0;
        clear_model();
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(posedge Clk); #1;
    endtask

    task automatic spi_write(input int idx, input logic [31:0] d);
        Spi_Addr    = {1'b1, 7'(idx)};
        Spi_Wr_Data = d;
        if (d != shadow_m && idx < N_REGS) model[idx] = d;
        shadow_m = d;
        @(posedge Clk); #1;
        Spi_Addr = {1'b0, 7'(idx)};
    endtask

    task automatic spi_read_check(input int idx, input string name);
        Spi_Addr = {1'b0, 7'(idx)};
        @(posedge Clk); #1;
        check(name, Spi_Rd_Data, model[idx]);
    endtask

    task automatic local_txn(input int id, input bit wr, input int idx, input logic [31:0] d,
                             output int lat);
        exp_t e;
        e.id = id;
        e.rd = !wr;
        if (wr) begin
            e.data = last_rdata_m;
            if (idx < N_REGS) model[idx] = d;
        end else begin
            e.data       = model[idx];
            last_rdata_m = e.data;
        end
        sb.push_back(e);
        Req_Valid[id]          = 1'b1;
        Req_Write[id]          = wr;
        Req_Addr[id*7 +: 7]    = 7'(idx);
        Req_Wdata[id*32 +: 32] = d;
        lat = 0;
        while (lat < 20) begin
            @(posedge Clk); #1;
            lat++;
            if (Req_Ready[id]) break;
        end
        if (!Req_Ready[id]) check("ready_timeout", 32'(Req_Ready[id]), 32'h1);
        Req_Valid[id] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        int   served [N_REQ];
        exp_t e;

        Reset_n   = 1'b0;
        Req_Addr  = '0;
        Req_Wdata = '0;
        do_reset();
        check("rst_spi_rd", Spi_Rd_Data, 32'h0);
        check("rst_ready", 32'(Req_Ready), 32'h0);
        check("rst_rdata", Req_Rdata, 32'h0);
        check("rst_err", 32'(Spi_Err), 32'h0);

        // Local write then SPI read-back with 1-cycle latency.
        Spi_Addr = 8'h05;
        @(posedge Clk); #1;
        check("spi_rd_idx5_init", Spi_Rd_Data, 32'h0);
        local_txn(0, 1'b1, 5, 32'h1234_5678, lat);
        check("write_latency", 32'(lat), 32'd2);
        check("spi_rd_old_same_cycle", Spi_Rd_Data, 32'h0);
        @(posedge Clk); #1;
        check("spi_rd_new", Spi_Rd_Data, model[5]);

        // SPI commit, local read-back, identical-value rewrite is a no-op.
        spi_write(3, 32'hCAFE_0001);
        spi_read_check(3, "spi_rd_idx3");
        local_txn(1, 1'b0, 3, 32'h0, lat);
        check("read_latency", 32'(lat), 32'd2);
        spi_write(4, 32'hCAFE_0001);
        spi_read_check(4, "spi_same_value_noop");

        // Out-of-range accesses.
        local_txn(2, 1'b1, 100, 32'hDEAD_BEEF, lat);
        local_txn(3, 1'b0, 100, 32'h0, lat);
        spi_read_check(100, "spi_rd_oor");
        spi_read_check(4, "oor_no_alias_4");
        spi_write(40, 32'h5555_AAAA);
        spi_read_check(8, "spi_oor_no_alias_8");

        // SPI commit coincident with ACCESS of req2: one-cycle stall, both writes land.
        e.id = 2; e.rd = 1'b0; e.data = last_rdata_m;
        sb.push_back(e);
        model[10] = 32'h1111_2222;
        Req_Valid[2] = 1'b1; Req_Write[2] = 1'b1;
        Req_Addr[2*7 +: 7] = 7'd10; Req_Wdata[2*32 +: 32] = 32'h1111_2222;
        @(posedge Clk); #1;
        Spi_Addr = 8'h8B; Spi_Wr_Data = 32'h0BAD_F00D;
        model[11] = 32'h0BAD_F00D; shadow_m = 32'h0BAD_F00D;
        @(posedge Clk); #1;
        check("stall_no_ready", 32'(Req_Ready), 32'h0);
        Spi_Addr = 8'h0B;
        @(posedge Clk); #1;
        check("ready_after_stall", 32'(Req_Ready), 32'h4);
        Req_Valid[2] = 1'b0;
        spi_read_check(10, "collide_local_write");
        spi_read_check(11, "collide_spi_write");

        // Round robin from pointer 0 with all requesters active.
        do_reset();
        for (int i = 20; i < 26; i++) spi_write(i, $urandom);
        for (int i = 0; i < N_REQ; i++) begin
            e.id = i; e.rd = 1'b1; e.data = model[20+i];
            sb.push_back(e);
            Req_Addr[i*7 +: 7] = 7'(20 + i);
            served[i] = 0;
        end
        e.id = 0; e.rd = 1'b1; e.data = model[25];
        sb.push_back(e);
        last_rdata_m = model[25];
        ready_cyc.delete();
        Req_Write = '0;
        Req_Valid = '1;
        for (int c = 0; c < 40 && Req_Valid != '0; c++) begin
            @(posedge Clk); #1;
            for (int i = 0; i < N_REQ; i++) begin
                if (Req_Ready[i]) begin
                    served[i]++;
                    if (i == 0 && served[0] == 1) Req_Addr[6:0] = 7'd25;
                    else Req_Valid[i] = 1'b0;
                end
            end
        end
        @(posedge Clk); #1;
        check("rr_count", 32'(ready_cyc.size()), 32'd5);
        for (int k = 1; k < ready_cyc.size(); k++)
            check("rr_spacing", 32'(ready_cyc[k] - ready_cyc[k-1]), 32'd2);

        // Randomized mixed traffic.
        for (int n = 0; n < 60; n++) begin
            int          idx;
            logic [31:0] d;
            idx = $urandom_range(0, 39);
            d   = $urandom;
            case ($urandom_range(0, 3))
                0: local_txn($urandom_range(0, N_REQ-1), 1'b1, idx, d, lat);
                1: local_txn($urandom_range(0, N_REQ-1), 1'b0, idx, d, lat);
                2: spi_write(idx, ($urandom_range(0, 3) == 0) ? shadow_m : d);
                default: spi_read_check(idx, "rand_spi_rd");
            endcase
        end
        for (int i = 0; i < N_REGS; i += 3) spi_read_check(i, "rand_final_rd");

        // Reset while req1 sits in ACCESS: no pulse, everything cleared.
        local_txn(1, 1'b1, 7, 32'h7777_7777, lat);
        Req_Valid[1] = 1'b1; Req_Write[1] = 1'b1;
        Req_Addr[1*7 +: 7] = 7'd9; Req_Wdata[1*32 +: 32] = 32'h9999_9999;
        @(posedge Clk); #1;
        Reset_n = 1'b0;
        Req_Valid = '0;
        Spi_Addr = '0;
        Spi_Wr_Data = '0;
        clear_model();
        #2;
        Reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge Clk); #1;
            check("abort_no_ready", 32'(Req_Ready), 32'h0);
        end
        check("abort_rdata", Req_Rdata, 32'h0);
        for (int i = 0; i < N_REGS; i++) spi_read_check(i, "abort_regs_zero");
        check("spi_err_default", 32'(Spi_Err), 32'h0);

        @(posedge Clk); #1;
        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
